pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC and target width.
REQ-002 The block SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2, range 1-15, giving the flush pulse length in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port stall, input, 1 bit; when high, the PC holds.
REQ-007 The block SHALL have port bcmp, input, 1 bit, the branch-comparison result.
REQ-008 The block SHALL have port branch, input, 1 bit, marking a conditional branch in EX.
REQ-009 The block SHALL have port jump, input, 1 bit, marking JAL in EX.
REQ-010 The block SHALL have port jalr, input, 1 bit, marking JALR in EX.
REQ-011 The block SHALL have port target, input, XLEN bits, the redirect target address.
REQ-012 The block SHALL have port trap, input, 1 bit, a trap request.
REQ-013 The block SHALL have port trap_vec, input, XLEN bits, the trap handler address.
REQ-014 The block SHALL have port pc, output, XLEN bits, the registered current PC.
REQ-015 The block SHALL have port pc_plus4, output, XLEN bits, equal to pc + 4, combinational, wrapping modulo 2^XLEN.
REQ-016 The block SHALL have port pcsrc, output, 1 bit, asserted combinationally in the cycle a redirect is accepted.
REQ-017 The block SHALL have port flush, output, 1 bit, registered, telling the IF/ID stages to squash.
REQ-018 The block SHALL have port pending, output, 1 bit, registered, high while a redirect is held during a stall.
REQ-019 The block SHALL have port misaligned, output, 1 bit, a registered one-cycle pulse on a misaligned target.

Function
REQ-020 A redirect request SHALL be defined as req = (bcmp && branch) || jump || jalr.
REQ-021 The effective target SHALL be target with bit 0 cleared when jalr=1, and target unmodified otherwise.
REQ-022 A request whose effective target has bits [1:0] != 2'b00 SHALL be rejected; misaligned = 1 on the next cycle, and the PC behaves as if req = 0.
REQ-023 The next PC SHALL be selected with this priority:
  - trap → trap_vec, applied even if stall = 1, and any pending redirect is cleared;
  - accepted req with stall = 0 → effective target;
  - pending with stall = 0 → the held target, and pending is cleared;
  - stall = 0 → pc_plus4;
  - otherwise → pc holds.
REQ-024 An accepted req with stall = 1 and pending = 0 SHALL latch the effective target and set pending on the next edge.
REQ-025 A req with stall = 1 and pending = 1 SHALL be ignored; the first held redirect wins.
REQ-026 A req with stall = 0 and pending = 1 SHALL take the new target and clear pending.
REQ-027 pcsrc SHALL be 1 in any cycle the PC loads a non-sequential value (trap, accepted req, or pending release), and 0 otherwise.
REQ-028 A 4-bit counter SHALL load FLUSH_CYCLES on each pcsrc cycle and decrement to 0 otherwise; flush = (counter != 0), so flush rises on the edge after pcsrc.
REQ-029 A new pcsrc while flush is high SHALL reload the counter, restarting the full FLUSH_CYCLES window.
REQ-030 The counter SHALL decrement regardless of stall.
REQ-031 A trap target SHALL NOT be alignment-checked.

Reset
REQ-032 With rst = 1 on an edge, pc SHALL become RESET_VEC and flush, pending, misaligned and the counter SHALL become 0, overriding all other inputs including trap.
REQ-033 Reset asserted mid-stall or mid-flush SHALL discard the held target and the remaining flush cycles.
REQ-034 In the first cycle after reset release with stall = 0, pc SHALL advance to RESET_VEC + 4.

Verification
REQ-035 The bench SHALL check: reset, then 3 free cycles → pc = 0, 4, 8, 12; flush = 0; pcsrc = 0.
REQ-036 The bench SHALL check: at pc = 0x10, branch = 1, bcmp = 1, target = 0x40 → pcsrc = 1 that cycle; pc = 0x40 next; flush = 1 for exactly 2 cycles.
REQ-037 The bench SHALL check: stall = 1, jump = 1, target = 0x80 for 1 cycle, then a second jump to 0xC0 while stalled, then stall = 0 → pending = 1 during the stall; pc = 0x80 one edge after stall drops; 0xC0 is never loaded.
REQ-038 The bench SHALL check: jalr = 1, target = 0x101 → pc = 0x100 (bit 0 cleared); jump = 1, target = 0x102 → misaligned pulses 1 cycle and pc = previous + 4.
REQ-039 The bench SHALL check: trap = 1, trap_vec = 0x200, together with branch taken to 0x40 and stall = 1 → pc = 0x200 next; pending = 0; flush window starts.
REQ-040 The bench SHALL check: pc = 0xFFFF_FFFC free-running → pc wraps to 0x0; and rst asserted during flush → flush = 0 and pc = RESET_VEC next edge.

Source files
------------

// File: rtl/pc_unit.sv
// Purpose: program-counter register with branch/jump/trap redirect, stall-held redirect and IF/ID flush pulse.
// Latency: pc updates one edge after the request; pcsrc is combinational; flush/pending/misaligned are registered.
// Backpressure: stall freezes the PC (traps still apply); a redirect seen under stall is held until stall drops.
module pc_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VEC    = '0,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            bcmp,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pcsrc,
  output logic            flush,
  output logic            pending,
  output logic            misaligned
);

  // Flush window length as loaded into the 4-bit down-counter (legal range 1..15).
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  // Architectural state.
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [XLEN-1:0] held_q,       held_d;
  logic            pending_q,    pending_d;
  logic            misaligned_q, misaligned_d;
  logic [3:0]      cnt_q,        cnt_d;
  logic            flush_q,      flush_d;

  // Request decode.
  logic            req;
  logic [XLEN-1:0] eff_tgt;
  logic            tgt_mis;
  logic            req_acc;
  logic            redirect;

  // Decode the redirect request and qualify its target alignment; traps bypass this check.
  always_comb begin
    req        = (bcmp && branch) || jump || jalr;
    eff_tgt    = target;
    if (jalr) begin
      eff_tgt[0] = 1'b0;
    end
    tgt_mis    = req && (eff_tgt[1:0] != 2'b00);
    req_acc    = req && !tgt_mis;
    pc_plus4   = pc_q + XLEN'(4);
  end

  // Next-PC priority: trap, live redirect, held redirect, sequential, hold.
  always_comb begin
    pc_d      = pc_q;
    held_d    = held_q;
    pending_d = pending_q;
    redirect  = 1'b0;

    if (trap) begin
      // Trap wins even under stall and discards any held redirect.
      pc_d      = trap_vec;
      pending_d = 1'b0;
      redirect  = 1'b1;
    end else if (!stall) begin
      if (req_acc) begin
        // A fresh redirect supersedes anything held.
        pc_d      = eff_tgt;
        pending_d = 1'b0;
        redirect  = 1'b1;
      end else if (pending_q) begin
        pc_d      = held_q;
        pending_d = 1'b0;
        redirect  = 1'b1;
      end else begin
        pc_d      = pc_plus4;
      end
    end else if (req_acc && !pending_q) begin
      // Stalled: remember only the first redirect; later ones are dropped.
      held_d    = eff_tgt;
      pending_d = 1'b1;
    end
  end

  // Flush counter reloads on every redirect and otherwise drains, independent of stall.
  always_comb begin
    misaligned_d = tgt_mis;
    if (redirect) begin
      cnt_d = FLUSH_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
    flush_d = (cnt_d != 4'd0);
  end

  // State register; reset overrides every input including trap and drops held/flush state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VEC;
      held_q       <= '0;
      pending_q    <= 1'b0;
      misaligned_q <= 1'b0;
      cnt_q        <= 4'd0;
      flush_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      held_q       <= held_d;
      pending_q    <= pending_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
    end
  end

  // Reset forces a RESET_VEC load, which is not a redirect, so pcsrc is masked.
  assign pcsrc      = redirect && !rst;
  assign pc         = pc_q;
  assign flush      = flush_q;
  assign pending    = pending_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: a driver applies one vector per cycle and queues its expected outputs;
// a monitor on the falling edge pops the queue and compares against the DUT.
// Expected values in the table are worked out by hand from the intended PC behaviour.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, bcmp, branch, jump, jalr, trap;
  logic [31:0] target, trap_vec;
  logic [31:0] pc, pc_plus4;
  logic        pcsrc, flush, pending, misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .bcmp(bcmp), .branch(branch),
    .jump(jump), .jalr(jalr), .target(target), .trap(trap), .trap_vec(trap_vec),
    .pc(pc), .pc_plus4(pc_plus4), .pcsrc(pcsrc), .flush(flush),
    .pending(pending), .misaligned(misaligned)
  );

  typedef struct {
    logic        rst, stall, bcmp, branch, jump, jalr, trap;
    logic [31:0] target, trap_vec;
    logic        chk;
    logic [31:0] e_pc;
    logic        e_pcsrc, e_flush, e_pend, e_mis;
  } vec_t;

  typedef struct {
    int          row;
    logic [31:0] e_pc;
    logic        e_pcsrc, e_flush, e_pend, e_mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, st, bc, br, jp, jr, input logic [31:0] tg,
                              input logic tr, input logic [31:0] tv, input logic c,
                              input logic [31:0] epc, input logic eps, efl, epd, ems);
    vec_t v;
    v.rst = r; v.stall = st; v.bcmp = bc; v.branch = br; v.jump = jp; v.jalr = jr;
    v.target = tg; v.trap = tr; v.trap_vec = tv; v.chk = c;
    v.e_pc = epc; v.e_pcsrc = eps; v.e_flush = efl; v.e_pend = epd; v.e_mis = ems;
    return v;
  endfunction

  task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("pc",         e.row, pc,                 e.e_pc);
      cmp("pc_plus4",   e.row, pc_plus4,           e.e_pc + 32'd4);
      cmp("pcsrc",      e.row, {31'd0, pcsrc},     {31'd0, e.e_pcsrc});
      cmp("flush",      e.row, {31'd0, flush},     {31'd0, e.e_flush});
      cmp("pending",    e.row, {31'd0, pending},   {31'd0, e.e_pend});
      cmp("misaligned", e.row, {31'd0, misaligned},{31'd0, e.e_mis});
    end
  end

  // Driver: build the vector table, then apply one row per cycle after the rising edge.
  initial begin
    rst = 1'b1; stall = 1'b0; bcmp = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    trap = 1'b0; target = 32'h0; trap_vec = 32'h0;

    //               rst st bc br jp jr target         tr trap_vec      chk pc             ps fl pd ms
    // reset then free-running
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h4,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h8,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'hC,         0, 0, 0, 0));
    // taken branch at 0x10 -> 0x40, two-cycle flush
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h40,        0, 32'h0,        1,  32'h10,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h40,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h44,        0, 1, 0, 0));
    // bcmp without branch, then branch not taken: sequential
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h40,        0, 32'h0,        1,  32'h48,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h40,        0, 32'h0,        1,  32'h4C,        0, 0, 0, 0));
    // jump under stall held, second jump ignored, released when stall drops
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h80,        0, 32'h0,        1,  32'h50,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'hC0,        0, 32'h0,        1,  32'h50,        0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h50,        0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h50,        1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h80,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h84,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h88,        0, 0, 0, 0));
    // jalr clears bit 0; misaligned jump rejected
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h101,       0, 32'h0,        1,  32'h8C,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h102,       0, 32'h0,        1,  32'h100,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h104,       0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h108,       0, 0, 0, 0));
    // jalr to 0x103 -> 0x102 still misaligned
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h103,       0, 32'h0,        1,  32'h10C,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h110,       0, 0, 0, 1));
    // trap with taken branch under stall
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h40,        1, 32'h200,      1,  32'h114,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h200,       0, 1, 0, 0));
    // held jump then trap to unaligned vector: pending cleared, vector used as-is
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h300,       0, 32'h0,        1,  32'h204,       0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         1, 32'h402,      1,  32'h204,       1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h402,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h406,       0, 1, 0, 0));
    // held jump overridden by new jump when stall drops
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h500,       0, 32'h0,        1,  32'h40A,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h600,       0, 32'h0,        1,  32'h40A,       1, 0, 1, 0));
    // redirect during flush restarts the window
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h700,       0, 32'h0,        1,  32'h600,       1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h700,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h704,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h708,       0, 0, 0, 0));
    // flush drains while stalled
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h800,       0, 32'h0,        1,  32'h70C,       1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h800,       0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h800,       0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h800,       0, 0, 0, 0));
    // wrap past the top of the address space
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF8, 0, 32'h0,        1,  32'h800,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'hFFFF_FFF8, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'hFFFF_FFFC, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h0,         0, 0, 0, 0));
    // reset mid-flush and mid-stall with trap asserted
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h900,       0, 32'h0,        1,  32'h4,         1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'hA00,       0, 32'h0,        1,  32'h900,       0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,         1, 32'h200,      1,  32'h900,       0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h4,         0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; stall = vecs[i].stall; bcmp = vecs[i].bcmp; branch = vecs[i].branch;
      jump = vecs[i].jump; jalr = vecs[i].jalr; target = vecs[i].target;
      trap = vecs[i].trap; trap_vec = vecs[i].trap_vec;
      if (vecs[i].chk) begin
        exp_t e;
        e.row = i; e.e_pc = vecs[i].e_pc; e.e_pcsrc = vecs[i].e_pcsrc;
        e.e_flush = vecs[i].e_flush; e.e_pend = vecs[i].e_pend; e.e_mis = vecs[i].e_mis;
        sb.push_back(e);
      end
    end

    // Give the monitor a bounded window to drain the scoreboard.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
